// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM (IDLE/GRACE/RUN/DEAD/OVER) plus single-cycle
// movement ticks, collision gating, score pulses and the datapath restart pulse.
// Valid/ready note: this block has no valid/ready handshakes; every output is a
// level (state, collide_en, dead) or a single-cycle pulse (ticks, score_inc, restart).
module game_sequencer #(
  parameter int unsigned WALL_DIV  = 166_667,
  parameter int unsigned BIRD_DIV  = 150_000,
  parameter int unsigned GRACE_CYC = 100_000_000,
  parameter int unsigned DEAD_HOLD = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_jmp,
  input  logic       i_collide,
  input  logic       i_floor_hit,
  input  logic       i_wall_pass,
  output logic [2:0] o_state,
  output logic       o_wall_tick,
  output logic       o_bird_tick,
  output logic       o_collide_en,
  output logic       o_dead,
  output logic       o_score_inc,
  output logic       o_restart
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRACE = 3'd1,
    S_RUN   = 3'd2,
    S_DEAD  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int WW = (WALL_DIV  > 1) ? $clog2(WALL_DIV)  : 1;
  localparam int BW = (BIRD_DIV  > 1) ? $clog2(BIRD_DIV)  : 1;
  localparam int GW = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1;
  localparam int DW = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;
  localparam int HW = (GW > DW) ? GW : DW;

  localparam logic [WW-1:0] WALL_LAST  = WW'(WALL_DIV - 1);
  localparam logic [BW-1:0] BIRD_LAST  = BW'(BIRD_DIV - 1);
  localparam logic [HW-1:0] GRACE_LAST = HW'(GRACE_CYC - 1);
  localparam logic [HW-1:0] DEAD_LAST  = HW'(DEAD_HOLD - 1);

  // State kept as a plain 3-bit vector so undefined encodings are representable.
  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic          r_jmp_q;
  logic          r_armed;
  logic [HW-1:0] r_hold_cnt;
  logic [WW-1:0] r_wall_cnt;
  logic [BW-1:0] r_bird_cnt;
  logic          r_wall_tick;
  logic          r_bird_tick;
  logic          r_score_inc;
  logic          r_restart;
  logic          w_restart_nxt;
  logic          w_press;
  logic          w_count_en;
  logic          w_next_count_en;
  logic          w_start;
  logic          w_die;
  logic          w_valid;

  // A button already held when reset releases is not a press: r_armed masks the
  // first cycle after reset, before r_jmp_q has sampled the real button level.
  assign w_press         = i_jmp & ~r_jmp_q & r_armed;
  assign w_count_en      = (r_state == S_GRACE) || (r_state == S_RUN);
  assign w_next_count_en = (w_next_state == S_GRACE) || (w_next_state == S_RUN);
  assign w_start         = (r_state == S_IDLE) && (w_next_state == S_GRACE);
  assign w_die           = (r_state == S_RUN) && (w_next_state == S_DEAD);
  assign w_valid         = (r_state <= S_OVER);

  // Next-state logic; restart is requested on the OVER -> IDLE press.
  always_comb begin
    w_next_state  = r_state;
    w_restart_nxt = 1'b0;
    case (r_state)
      S_IDLE:  if (w_press) w_next_state = S_GRACE;
      S_GRACE: if (r_hold_cnt == GRACE_LAST) w_next_state = S_RUN;
      S_RUN:   if (i_collide | i_floor_hit) w_next_state = S_DEAD;
      S_DEAD:  if (r_hold_cnt == DEAD_LAST) w_next_state = S_OVER;
      S_OVER: begin
        if (w_press) begin
          w_next_state  = S_IDLE;
          w_restart_nxt = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register and button edge-detect history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_jmp_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_jmp_q <= i_jmp;
      r_armed <= 1'b1;
    end
  end

  // Shared grace/dead-hold counter: cleared on entry to GRACE and to DEAD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_cnt <= '0;
    end else if (w_start || w_die) begin
      r_hold_cnt <= '0;
    end else if ((r_state == S_GRACE) || (r_state == S_DEAD)) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end

  // Wrapping tick dividers; they only advance while the game is moving.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wall_cnt <= '0;
      r_bird_cnt <= '0;
    end else if (w_start) begin
      r_wall_cnt <= '0;
      r_bird_cnt <= '0;
    end else if (w_count_en) begin
      r_wall_cnt <= (r_wall_cnt == WALL_LAST) ? '0 : r_wall_cnt + WW'(1);
      r_bird_cnt <= (r_bird_cnt == BIRD_LAST) ? '0 : r_bird_cnt + BW'(1);
    end
  end

  // Registered pulses; a tick is dropped when the game stops on that same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wall_tick <= 1'b0;
      r_bird_tick <= 1'b0;
      r_score_inc <= 1'b0;
      r_restart   <= 1'b0;
    end else begin
      r_wall_tick <= w_count_en & w_next_count_en & (r_wall_cnt == WALL_LAST);
      r_bird_tick <= w_count_en & w_next_count_en & (r_bird_cnt == BIRD_LAST);
      r_score_inc <= o_wall_tick & i_wall_pass & (r_state == S_RUN);
      r_restart   <= w_restart_nxt;
    end
  end

  assign o_state      = r_state;
  assign o_wall_tick  = r_wall_tick & w_count_en;
  assign o_bird_tick  = r_bird_tick & w_count_en;
  assign o_collide_en = (r_state == S_RUN);
  assign o_dead       = (r_state == S_DEAD) || (r_state == S_OVER);
  assign o_score_inc  = r_score_inc & w_valid;
  assign o_restart    = r_restart & w_valid;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small divider/hold parameters.
module tb_game_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRACE = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DEAD  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       jmp;
  logic       collide;
  logic       floor_hit;
  logic       wall_pass;
  logic [2:0] state;
  logic       wall_tick;
  logic       bird_tick;
  logic       collide_en;
  logic       dead;
  logic       score_inc;
  logic       restart;

  // Observed vector: {state, wall_tick, bird_tick, collide_en, dead, score_inc, restart}
  logic [8:0] obs;
  logic [8:0] exp_v;
  logic [2:0] e_st;
  logic       e_wt, e_bt, e_ce, e_dd, e_sc, e_rs;
  int         n_checks = 0;
  int         n_fail   = 0;

  assign obs = {state, wall_tick, bird_tick, collide_en, dead, score_inc, restart};

  game_sequencer #(
    .WALL_DIV(4), .BIRD_DIV(3), .GRACE_CYC(20), .DEAD_HOLD(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_jmp(jmp), .i_collide(collide),
    .i_floor_hit(floor_hit), .i_wall_pass(wall_pass),
    .o_state(state), .o_wall_tick(wall_tick), .o_bird_tick(bird_tick),
    .o_collide_en(collide_en), .o_dead(dead), .o_score_inc(score_inc),
    .o_restart(restart)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; jmp = 1'b0; collide = 1'b0; floor_hit = 1'b0; wall_pass = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with jmp low; returns at the negedge of GRACE cycle 0.
  task automatic start_grace();
    jmp = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; jmp = 1'b1; collide = 1'b0; floor_hit = 1'b0; wall_pass = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_v = {ST_IDLE, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, exp_v);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = {ST_IDLE, 6'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL held_jmp_idle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    jmp = 1'b0;
    @(negedge clk);
    exp_v = {ST_IDLE, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL released_idle got=%b exp=%b", obs, exp_v);
    end
    jmp = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
    exp_v = {ST_GRACE, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL press_to_grace got=%b exp=%b", obs, exp_v);
    end
  endtask

  // collide held through GRACE: ignored, RUN at 20, DEAD at 21.
  task automatic test_grace();
    do_reset();
    start_grace();
    collide = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k > 0) @(negedge clk);
      e_st = (k < 20) ? ST_GRACE : ((k == 20) ? ST_RUN : ST_DEAD);
      e_wt = (k > 0) && (k % 4 == 0) && (k <= 20);
      e_bt = (k > 0) && (k % 3 == 0) && (k <= 20);
      e_ce = (k == 20);
      e_dd = (k == 21);
      exp_v = {e_st, e_wt, e_bt, e_ce, e_dd, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL grace_ticks k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
    collide = 1'b0;
  endtask

  // wall_pass high all through GRACE (no score), then on a RUN tick (k=24)
  // and on a RUN non-tick cycle (k=26): only one pulse, at k=25.
  task automatic test_score();
    do_reset();
    start_grace();
    for (int k = 0; k < 29; k++) begin
      if (k > 0) @(negedge clk);
      wall_pass = (k < 20) || (k == 24) || (k == 26);
      e_st = (k < 20) ? ST_GRACE : ST_RUN;
      e_wt = (k > 0) && (k % 4 == 0);
      e_bt = (k > 0) && (k % 3 == 0);
      e_ce = (k >= 20);
      e_sc = (k == 25);
      exp_v = {e_st, e_wt, e_bt, e_ce, 1'b0, e_sc, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL score k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
    wall_pass = 1'b0;
  endtask

  // Continues from RUN cycle 28: floor_hit -> DEAD, press ignored, OVER, restart.
  task automatic test_dead_over();
    @(negedge clk);
    floor_hit = 1'b1;
    exp_v = {ST_RUN, 1'b0, 1'b0, 1'b1, 3'b000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL pre_floor got=%b exp=%b", obs, exp_v);
    end
    for (int d = 0; d < 12; d++) begin
      @(negedge clk);
      floor_hit = 1'b0;
      jmp = (d == 2) || (d == 9);
      e_st = (d < 8) ? ST_DEAD : ((d < 10) ? ST_OVER : ST_IDLE);
      e_dd = (d < 10);
      e_rs = (d == 10);
      exp_v = {e_st, 1'b0, 1'b0, 1'b0, e_dd, 1'b0, e_rs};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL dead_over d=%0d got=%b exp=%b", d, obs, exp_v);
      end
    end
    jmp = 1'b0;
  endtask

  // Async reset in DEAD and mid-count in RUN; next GRACE ticks restart from 0.
  task automatic test_rst_mid();
    do_reset();
    start_grace();
    collide = 1'b1;
    repeat (21) @(negedge clk);
    collide = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = {ST_DEAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL in_dead got=%b exp=%b", obs, exp_v);
    end
    rst = 1'b1;
    #1;
    exp_v = {ST_IDLE, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL rst_in_dead got=%b exp=%b", obs, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_grace();
    repeat (22) @(negedge clk);
    exp_v = {ST_RUN, 1'b0, 1'b0, 1'b1, 3'b000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL run_c22 got=%b exp=%b", obs, exp_v);
    end
    rst = 1'b1;
    #1;
    exp_v = {ST_IDLE, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL rst_in_run got=%b exp=%b", obs, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_grace();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      e_wt = (k == 4);
      e_bt = (k == 3) || (k == 6);
      exp_v = {ST_GRACE, e_wt, e_bt, 4'b0000};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL ticks_after_rst k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  // Undefined state 5 -> IDLE; collide together with wall_pass on a RUN tick.
  task automatic test_illegal_and_collide();
    do_reset();
    force dut.r_state = 3'd5;
    #1;
    release dut.r_state;
    #1;
    exp_v = {3'd5, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL illegal_state got=%b exp=%b", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {ST_IDLE, 6'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL illegal_recover got=%b exp=%b", obs, exp_v);
    end
    start_grace();
    repeat (20) @(negedge clk);
    collide = 1'b1;
    wall_pass = 1'b1;
    exp_v = {ST_RUN, 1'b1, 1'b0, 1'b1, 3'b000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL run_tick_c20 got=%b exp=%b", obs, exp_v);
    end
    @(negedge clk);
    collide = 1'b0;
    wall_pass = 1'b0;
    exp_v = {ST_DEAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL score_and_dead got=%b exp=%b", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {ST_DEAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL score_width got=%b exp=%b", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_grace();
    test_score();
    test_dead_over();
    test_rst_mid();
    test_illegal_and_collide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
